wb_arbiter: RTL

Write-back arbiter sitting directly upstream of the register file's single write port in the rv32i processor. It merges two result producers: the in-order pipeline (fixed latency, no backpressure) and a long-latency unit (loads/multi-cycle ops, valid/ready). Long-latency results are buffered in a small FIFO, and a pending-register scoreboard lets decode detect read-after-write hazards on outstanding destinations. Outputs are registered and drive the register file's reg_write / rd / write_data directly.

---
 rtl/rv_wb_pkg.sv | 7 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared widths and write-back source select for the rv32i write-back path.
package rv_wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_LU} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with occupancy count; DEPTH must be a power of two.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and long-latency results onto the single register-file write port,
// tracking outstanding long-latency destinations and requesting bubbles when the buffer head starves.
module wb_arbiter import rv_wb_pkg::*; #(
    parameter int XLEN         = rv_wb_pkg::XLEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pipe_valid_i,
    input  logic [REG_ADDR_W-1:0] pipe_rd_i,
    input  logic [XLEN-1:0]       pipe_data_i,
    input  logic                  lu_valid_i,
    output logic                  lu_ready_o,
    input  logic [REG_ADDR_W-1:0] lu_rd_i,
    input  logic [XLEN-1:0]       lu_data_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  busy_rs1_o,
    output logic                  busy_rs2_o,
    output logic                  stall_req_o,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       write_data_o
);
    localparam int EW  = REG_ADDR_W + XLEN;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int AGW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0]         head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  fifo_full, fifo_empty, push, pop, pipe_wr;
    logic [CW-1:0]         fifo_cnt;
    wb_src_e               src;

    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [AGW-1:0]        age_q, age_d;

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({lu_rd_i, lu_data_i}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign head_rd      = head[EW-1 -: REG_ADDR_W];
    assign head_data    = head[XLEN-1:0];
    assign lu_ready_o   = rst_ni && !fifo_full;
    assign busy_rs1_o   = pending_q[rs1_i];
    assign busy_rs2_o   = pending_q[rs2_i];
    assign stall_req_o  = age_q == AGW'(STARVE_LIMIT);
    assign reg_write_o  = reg_write_q;
    assign rd_o         = rd_q;
    assign write_data_o = data_q;

    // A pipe write to x0 is a no-write and must not block the FIFO head.
    always_comb begin
        pipe_wr = pipe_valid_i && pipe_rd_i != '0;
        pop     = !pipe_wr && !fifo_empty;
        push    = lu_valid_i && lu_ready_o && lu_rd_i != '0;
        src     = pipe_wr ? WB_PIPE : pop ? WB_LU : WB_NONE;
    end

    always_comb begin
        reg_write_d = src != WB_NONE;
        rd_d        = src == WB_PIPE ? pipe_rd_i : src == WB_LU ? head_rd : rd_q;
        data_d      = src == WB_PIPE ? pipe_data_i : src == WB_LU ? head_data : data_q;
        age_d       = (fifo_cnt == '0 || pop) ? '0 : stall_req_o ? age_q : age_q + 1'b1;
    end

    // Issue is applied after the pop clear so a same-cycle re-issue keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (pop) pending_d[head_rd] = 1'b0;
        if (issue_valid_i) pending_d[issue_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            pending_q   <= '0;
            age_q       <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            pending_q   <= pending_d;
            age_q       <= age_d;
        end
    end
endmodule
